// File: rtl/ex_muldiv_pkg.sv
// Shared opcode codes, state encoding and sizes for the EX-stage multiply/divide unit.
package ex_muldiv_pkg;

  localparam int unsigned RegAddrW = 5;
  localparam int unsigned MdOpW    = 3;

  localparam logic [MdOpW-1:0] InstMul    = 3'd0;
  localparam logic [MdOpW-1:0] InstMulh   = 3'd1;
  localparam logic [MdOpW-1:0] InstMulhsu = 3'd2;
  localparam logic [MdOpW-1:0] InstMulhu  = 3'd3;
  localparam logic [MdOpW-1:0] InstDiv    = 3'd4;
  localparam logic [MdOpW-1:0] InstDivu   = 3'd5;
  localparam logic [MdOpW-1:0] InstRem    = 3'd6;
  localparam logic [MdOpW-1:0] InstRemu   = 3'd7;

  localparam logic [6:0] InstTypeM = 7'b0000001;

  typedef enum logic [1:0] {MdIdle, MdCalc, MdSignFix, MdDone} md_state_e;

  // funct3[2] clear selects the multiply family.
  function automatic logic is_mul_op(logic [MdOpW-1:0] op);
    return !op[2];
  endfunction

endpackage

// File: rtl/ex_muldiv_neg.sv
// Combinational conditional two's-complement: out = en ? -in : in.
module ex_muldiv_neg #(
  parameter int unsigned XLEN = 32
) (
  input  logic            en_i,
  input  logic [XLEN-1:0] in_i,
  output logic [XLEN-1:0] out_o
);

  assign out_o = en_i ? (~in_i + XLEN'(1)) : in_i;

endmodule

// File: rtl/ex_muldiv.sv
// Iterative RV32M/RV64M multiply (radix-2 shift-add) and divide (restoring) unit.
// Define EX_MULDIV_ZERO_SKIP_EN to finish multiplies with a zero operand in one cycle.
module ex_muldiv
  import ex_muldiv_pkg::*;
#(
  parameter  int unsigned XLEN  = 32,
  localparam int unsigned CNT_W = $clog2(XLEN) + 1
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                start_i,
  input  logic                flush_i,
  input  logic [MdOpW-1:0]    op_i,
  input  logic [XLEN-1:0]     op1_i,
  input  logic [XLEN-1:0]     op2_i,
  input  logic [RegAddrW-1:0] rd_addr_i,
  output logic                busy_o,
  output logic                done_o,
  output logic [XLEN-1:0]     result_o,
  output logic [RegAddrW-1:0] rd_addr_o,
  output logic                regs_wen_o
);

  md_state_e             state_q;
  logic [CNT_W-1:0]      cnt_q;
  logic [MdOpW-1:0]      op_q;
  logic                  sign_q;
  logic [XLEN-1:0]       b_q;
  logic [2*XLEN-1:0]     acc_q;
  logic [XLEN-1:0]       result_q;
  logic [RegAddrW-1:0]   rd_pend_q, rd_q;
  logic                  done_q;

  logic                  op1_signed, op2_signed, op1_neg, op2_neg, res_sign;
  logic                  div_zero, div_ovf, zero_mul;
  logic [XLEN-1:0]       op1_mag, op2_mag, special_res;
  logic [XLEN-1:0]       acc_hi, acc_lo;
  logic [XLEN:0]         mul_sum, div_shift, div_diff;
  logic                  div_ge;
  logic [2*XLEN-1:0]     mul_next, div_next;
  logic                  lo_sel, mulh_op;
  logic [XLEN-1:0]       fix_in, fix_neg, fixed_res;

  always_comb begin
    op1_signed  = op_i inside {InstMulh, InstMulhsu, InstDiv, InstRem};
    op2_signed  = op_i inside {InstMulh, InstDiv, InstRem};
    op1_neg     = op1_signed & op1_i[XLEN-1];
    op2_neg     = op2_signed & op2_i[XLEN-1];
    // Remainder takes the dividend's sign; product and quotient take the XOR.
    res_sign    = op_i[2] & op_i[1] ? op1_neg : (op1_neg ^ op2_neg);
    div_zero    = op_i[2] && (op2_i == '0);
    div_ovf     = (op_i == InstDiv || op_i == InstRem) &&
                  (op1_i == {1'b1, {(XLEN-1){1'b0}}}) && (op2_i == '1);
    special_res = div_zero ? (op_i[1] ? op1_i : '1) : (op_i[1] ? '0 : op1_i);
`ifdef EX_MULDIV_ZERO_SKIP_EN
    zero_mul    = is_mul_op(op_i) && (op1_i == '0 || op2_i == '0);
`else
    zero_mul    = 1'b0;
`endif
  end

  ex_muldiv_neg #(.XLEN(XLEN)) u_neg_op1 (.en_i(op1_neg), .in_i(op1_i), .out_o(op1_mag));
  ex_muldiv_neg #(.XLEN(XLEN)) u_neg_op2 (.en_i(op2_neg), .in_i(op2_i), .out_o(op2_mag));

  always_comb begin
    acc_hi    = acc_q[2*XLEN-1:XLEN];
    acc_lo    = acc_q[XLEN-1:0];
    mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, b_q} : '0);
    mul_next  = {mul_sum, acc_lo[XLEN-1:1]};
    div_shift = acc_q[2*XLEN-1:XLEN-1];
    div_diff  = div_shift - {1'b0, b_q};
    div_ge    = div_shift >= {1'b0, b_q};
    div_next  = {(div_ge ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0]), acc_lo[XLEN-2:0], div_ge};
    lo_sel    = (op_q == InstMul) || (op_q == InstDiv) || (op_q == InstDivu);
    mulh_op   = is_mul_op(op_q) && (op_q != InstMul);
    fix_in    = lo_sel ? acc_lo : acc_hi;
  end

  ex_muldiv_neg #(.XLEN(XLEN)) u_neg_res (.en_i(sign_q), .in_i(fix_in), .out_o(fix_neg));

  // Negating the high half of a 2*XLEN product only carries in when the low half is zero.
  assign fixed_res = (mulh_op && sign_q && acc_lo != '0) ? ~acc_hi : fix_neg;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= MdIdle;
      cnt_q     <= '0;
      op_q      <= '0;
      sign_q    <= 1'b0;
      b_q       <= '0;
      acc_q     <= '0;
      result_q  <= '0;
      rd_pend_q <= '0;
      rd_q      <= '0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        MdIdle: begin
          if (start_i && !flush_i) begin
            op_q      <= op_i;
            rd_pend_q <= rd_addr_i;
            if (div_zero || div_ovf || zero_mul) begin
              result_q <= (div_zero || div_ovf) ? special_res : '0;
              rd_q     <= rd_addr_i;
              done_q   <= 1'b1;
              state_q  <= MdDone;
            end else begin
              sign_q  <= res_sign;
              b_q     <= op_i[2] ? op2_mag : op1_mag;
              acc_q   <= {{XLEN{1'b0}}, (op_i[2] ? op1_mag : op2_mag)};
              cnt_q   <= CNT_W'(XLEN);
              state_q <= MdCalc;
            end
          end
        end
        MdCalc: begin
          if (flush_i) begin
            state_q <= MdIdle;
          end else begin
            acc_q <= op_q[2] ? div_next : mul_next;
            cnt_q <= cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) state_q <= MdSignFix;
          end
        end
        MdSignFix: begin
          if (flush_i) begin
            state_q <= MdIdle;
          end else begin
            result_q <= fixed_res;
            rd_q     <= rd_pend_q;
            done_q   <= 1'b1;
            state_q  <= MdDone;
          end
        end
        MdDone: state_q <= MdIdle;
        default: state_q <= MdIdle;
      endcase
    end
  end

  assign busy_o     = (state_q != MdIdle);
  assign done_o     = done_q;
  assign regs_wen_o = done_q;
  assign result_o   = result_q;
  assign rd_addr_o  = rd_q;

endmodule

// File: doc/ex_muldiv.md
Name: ex_muldiv

Overview:
- Parametrised iterative multiply/divide unit for the EX stage. It implements the RV32M/RV64M operations MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM and REMU.
- It sits beside the single-cycle ALU. The ALU launches it with a one-cycle start pulse and holds the pipeline while busy_o is high.
- The unit returns one result with the destination register tag and a one-cycle done strobe, which is then muxed into ex_mem.
- The multiplier is radix-2 shift-add. The divider is restoring, one bit per cycle.

Parameters:
- XLEN, 32, operand/result width; legal values 32 and 64.
- CNT_W, $clog2(XLEN)+1, iteration counter width; derived, not overridden.

Ports:
- clk  in  1  clock, rising edge
- rstn  in  1  asynchronous active-low reset
- start_i  in  1  launch request; sampled only in IDLE
- flush_i  in  1  abort in-flight operation (branch/trap flush)
- op_i  in  3  operation, equal to inst funct3 (0=MUL .. 7=REMU)
- op1_i  in  XLEN  rs1 value / dividend / multiplicand
- op2_i  in  XLEN  rs2 value / divisor / multiplier
- rd_addr_i  in  `RegAddrBus  destination tag
- busy_o  out  1  high whenever state != IDLE
- done_o  out  1  one-cycle strobe; result valid
- result_o  out  XLEN  result, held until the next done
- rd_addr_o  out  `RegAddrBus  tag captured at start
- regs_wen_o  out  1  equals done_o

Behaviour:
- Interface (already decided): one clock, clk; reset is asynchronous, active-low, rstn.
- Reset values: state=IDLE; busy_o, done_o, regs_wen_o, result_o and rd_addr_o all 0. Reset asserted mid-operation takes effect immediately; no done is produced.
- States: IDLE, CALC, SIGN_FIX, DONE.
- Start capture: start_i=1 in IDLE latches op_i, the operands and rd_addr_i.
  - Operand magnitudes are taken per op: signed for MULH, DIV and REM; rs1 only for MULHSU.
  - The result sign is also captured: XOR of the operand signs for product and quotient; dividend sign for remainder.
- Normal path: IDLE→CALC. CALC runs exactly XLEN cycles, with the counter decrementing from XLEN to 1. Then CALC→SIGN_FIX, which conditionally negates the result (one cycle). Then SIGN_FIX→DONE.
- Latency: start sampled at the end of cycle T gives done_o=1 in cycle T+XLEN+2.
- DONE lasts one cycle: done_o=1 and regs_wen_o=1, then →IDLE.
- Result selection: MUL takes the low XLEN bits of the 2·XLEN product; MULH, MULHSU and MULHU take the high XLEN bits.
- Special cases resolve directly IDLE→DONE, with done_o in cycle T+1:
  - divide by zero: DIV/DIVU give all-ones; REM/REMU give op1_i.
  - signed overflow (op1=most-negative, op2=-1): DIV gives most-negative; REM gives 0.
- start_i while busy_o=1 is ignored. A start is not accepted in the DONE cycle. The earliest back-to-back start is the cycle after DONE.
- flush_i=1 in any non-IDLE state → IDLE next cycle, with no done_o. result_o and rd_addr_o keep their previous values.
- flush_i and start_i together in IDLE: flush wins and the start is dropped.
- Operand inputs need not be held after the start cycle.

Optional Feature:
- Macro EX_MULDIV_ZERO_SKIP_EN.
- When defined, any MUL-family op with op1_i==0 or op2_i==0 takes IDLE→DONE with result 0, so done_o arrives in cycle T+1.
- When undefined, a zero multiply takes the full XLEN+2 cycles and gives the same result.
- Division special cases are unaffected either way.

Decomposition:
- defines.v:
  - `INST_MUL..`INST_REMU (3-bit funct3 codes)
  - `INST_TYPE_M funct7 value (7'b0000001)
  - state encodings `MD_IDLE, `MD_CALC, `MD_SIGN_FIX, `MD_DONE
  - `MD_OP_W
- One sub-module, ex_muldiv_neg: a combinational XLEN-wide conditional two's-complement (out = en ? -in : in). It is instanced for op1 magnitude, op2 magnitude and final sign fix.

Test Plan:
- MUL op1=7, op2=0xFFFFFFFD → result_o=0xFFFFFFEB, done_o in cycle T+34, rd_addr_o=5 as launched, busy_o high for cycles T+1..T+34.
- op1=op2=0x80000000: MULH→0x40000000, MULHU→0x40000000. op1=op2=0xFFFFFFFF: MULHSU→0xFFFFFFFF, MULHU→0xFFFFFFFE.
- DIV 0xFFFFFFF9/2 → 0xFFFFFFFD. REM on the same operands → 0xFFFFFFFF. DIVU 100/7 → 14. REMU 100/7 → 2.
- Division special cases, each done in cycle T+1:
  - DIV 5/0 → 0xFFFFFFFF; REMU 5/0 → 5.
  - DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM on the same operands → 0.
- Flush and start interactions:
  - DIVU launched; flush_i at T+10 → busy_o=0 at T+11, no done_o.
  - New start at T+11 completes normally.
  - A start asserted at T+5 (mid-op) is ignored.
- Reset mid-operation: rstn low at T+20 → all outputs 0 immediately. With EX_MULDIV_ZERO_SKIP_EN, MUL 0×9 → result 0 with done_o in cycle T+1.
